// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// State encodings, grant identifiers, the watchdog fill word and a
// counter-width helper used by the top and the watchdog.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_I = 2'd1,
      ST_GNT_D = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_DM = 1'b1
   } grant_e;

   // Read data returned to a requester whose transaction was aborted
   localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

   // Counter width able to hold 0..limit
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_wdog.sv
// mem_arb_wdog: grant watchdog, built only when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk_in   - system clock, rising edge
//   reset    - asynchronous active-low reset
//   clr      - clears the count (asserted on a new grant)
//   en       - counts one per cycle while a grant is outstanding
//   expire_c - high in the cycle whose edge brings the count to TIMEOUT
module mem_arb_wdog
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturating up-counter with priority clear
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_c = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the data port of a CPU core, round robin on simultaneous requests.
// Ports:
//   clk_in, reset                     - clock (rising edge), async active-low reset
//   if_req/if_addr -> if_rdata/if_ack - fetch request, data and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata     - data request (read or write)
//   dm_rdata/dm_ack                   - load data and completion pulse
//   mem_cs/mem_we/mem_addr/mem_wdata  - memory command, stable while granted
//   mem_rdata/mem_ready               - memory response
//   busy                              - high whenever a grant is outstanding
//   timeout_err                       - one-cycle pulse on watchdog abort
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a grant after TIMEOUT
// cycles without mem_ready; otherwise a grant waits indefinitely.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              timeout_err
);

   localparam logic [DATA_W-1:0] FILL_DATA = DATA_W'(TIMEOUT_FILL);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT must be at least 1");
   end

   state_e            state_q,       state_d;
   grant_e            last_grant_q,  last_grant_d;
   logic              mem_cs_q,      mem_cs_d;
   logic              mem_we_q,      mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q,    if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q,    dm_rdata_d;
   logic              if_ack_q,      if_ack_d;
   logic              dm_ack_q,      dm_ack_d;
   logic              busy_q,        busy_d;
   logic              timeout_err_q, timeout_err_d;

   logic if_vld;
   logic dm_vld;
   logic grant;
   logic abort;

   // A request is invisible in its own ack cycle so a held request is not re-granted
   assign if_vld = if_req && !if_ack_q;
   assign dm_vld = dm_req && !dm_ack_q;
   assign grant  = (state_q == ST_IDLE) && (if_vld || dm_vld);

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_in   (clk_in),
      .reset    (reset),
      .clr      (grant),
      .en       (state_q != ST_IDLE),
      .expire_c (abort)
   );
`else
   assign abort = 1'b0;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      mem_cs_d      = mem_cs_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      dm_rdata_d    = dm_rdata_q;
      if_ack_d      = 1'b0;
      dm_ack_d      = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Data wins when alone or when fetch had the last grant
            if (dm_vld && (!if_vld || (last_grant_q == GRANT_IF))) begin
               state_d      = ST_GNT_D;
               last_grant_d = GRANT_DM;
               mem_cs_d     = 1'b1;
               mem_we_d     = dm_we;
               mem_addr_d   = dm_addr;
               mem_wdata_d  = dm_wdata;
            end else if (if_vld) begin
               state_d      = ST_GNT_I;
               last_grant_d = GRANT_IF;
               mem_cs_d     = 1'b1;
               mem_we_d     = 1'b0;
               mem_addr_d   = if_addr;
               mem_wdata_d  = '0;
            end
         end
         ST_GNT_I, ST_GNT_D: begin
            // mem_ready beats a watchdog expiry in the same cycle
            if (mem_ready || abort) begin
               state_d       = ST_IDLE;
               mem_cs_d      = 1'b0;
               mem_we_d      = 1'b0;
               timeout_err_d = !mem_ready;
               if (state_q == ST_GNT_I) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_ready ? mem_rdata : FILL_DATA;
               end else begin
                  dm_ack_d = 1'b1;
                  if (!mem_ready) begin
                     dm_rdata_d = FILL_DATA;
                  end else if (!mem_we_q) begin
                     dm_rdata_d = mem_rdata;
                  end
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            mem_cs_d = 1'b0;
            mem_we_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= GRANT_IF;
         mem_cs_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         dm_rdata_q    <= '0;
         if_ack_q      <= 1'b0;
         dm_ack_q      <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         mem_cs_q      <= mem_cs_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         dm_rdata_q    <= dm_rdata_d;
         if_ack_q      <= if_ack_d;
         dm_ack_q      <= dm_ack_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_cs      = mem_cs_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign if_rdata    = if_rdata_q;
   assign dm_rdata    = dm_rdata_q;
   assign if_ack      = if_ack_q;
   assign dm_ack      = dm_ack_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
